mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 198 +++++++++++++++++++
 tb/tb_mc_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle control unit for an ARM-subset datapath: instruction FSM,
// condition evaluation against the NZCV flags, and datapath select/enable decode.
module mc_controller (
    input  logic         clk,
    input  logic         Reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUCtrl
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
        StMemWr, StExecR, StExecI, StAluWb, StBranch
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flags_q;
    logic        cond_ex, cond_ex_q;
    logic [1:0]  reg_src_q, imm_src_q;
    logic [1:0]  dec_reg_src;
    logic [1:0]  cmd_alu;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic        i_bit, s_bit, is_cmp, rd_pc;
    logic [3:0]  cmd;
    logic        unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign i_bit     = Instr[25];
    assign cmd       = Instr[24:21];
    assign s_bit     = Instr[20];
    assign rd_pc     = (Instr[15:12] == 4'd15);
    assign is_cmp    = (cmd == 4'b1010);
    assign unused_rn = ^Instr[19:16];

    assign dec_reg_src = {(op == 2'b01) && !s_bit, (op == 2'b10)};

    // Flags are {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = !flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = !flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = !flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = !flags_q[0];
            4'b1000: cond_ex = flags_q[1] && !flags_q[2];
            4'b1001: cond_ex = !flags_q[1] || flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        cmd_alu = 2'b00;
        case (cmd)
            4'b0100: cmd_alu = 2'b00;
            4'b0010: cmd_alu = 2'b01;
            4'b1010: cmd_alu = 2'b01;
            4'b0000: cmd_alu = 2'b10;
            4'b1100: cmd_alu = 2'b11;
            default: cmd_alu = 2'b00;
        endcase
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    2'b00:   state_d = i_bit ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = s_bit ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
            reg_src_q <= 2'b00;
            imm_src_q <= 2'b00;
        end else begin
            state_q <= state_d;
            // Condition is frozen on pre-instruction flags
            if (state_q == StDecode) begin
                cond_ex_q <= cond_ex;
                reg_src_q <= dec_reg_src;
                imm_src_q <= op;
            end
            if ((state_q == StExecR || state_q == StExecI) && s_bit && cond_ex_q) begin
                flags_q <= ALUFlags;
            end
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        RegSrc    = reg_src_q;
        ImmSrc    = imm_src_q;
        ALUCtrl   = 2'b00;
        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = 2'b00;
                ImmSrc    = 2'b00;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = dec_reg_src;
                ImmSrc    = op;
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc = 1'b1;
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_q;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex_q;
                PCWrite   = cond_ex_q && rd_pc;
            end
            StExecR:  ALUCtrl = cmd_alu;
            StExecI: begin
                ALUSrcB = 2'b01;
                ALUCtrl = cmd_alu;
            end
            StAluWb: begin
                RegWrite = cond_ex_q && !is_cmp;
                PCWrite  = cond_ex_q && !is_cmp && rd_pc;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex_q;
            end
            default: ;
        endcase
        // Reset aborts any write and parks the selects at their fetch values
        if (!Reset) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IRWrite   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            RegSrc    = 2'b00;
            ImmSrc    = 2'b00;
            ALUCtrl   = 2'b00;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instructions plus random ones,
// compared cycle by cycle against an instruction-level expectation model.
module tb_mc_controller;

    logic         clk = 1'b0;
    logic         Reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]   ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUCtrl;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0]  mflags;
    logic [15:0] exp_q[$];
    logic [15:0] obs;

    mc_controller dut (
        .clk       (clk),
        .Reset     (Reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .RegSrc    (RegSrc),
        .ImmSrc    (ImmSrc),
        .ALUCtrl   (ALUCtrl)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUCtrl};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] vec(input bit pcw, input bit mw, input bit rw,
                                        input bit irw, input bit adr, input bit sa,
                                        input logic [1:0] sb, input logic [1:0] rs,
                                        input logic [1:0] rg, input logic [1:0] im,
                                        input logic [1:0] ac);
        return {pcw, mw, rw, irw, adr, sa, sb, rs, rg, im, ac};
    endfunction

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] fetch_vec();
        return vec(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    endfunction

    function automatic logic [15:0] reset_vec();
        return vec(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    endfunction

    // Expected per-cycle output vectors for one instruction, FETCH first
    task automatic build_expect(input logic [31:0] ins, input logic [3:0] af);
        logic [3:0] cmd;
        logic [1:0] op, rg, im, ac;
        bit pass, ib, sb, pc_dst, wr;
        op     = ins[27:26];
        ib     = ins[25];
        cmd    = ins[24:21];
        sb     = ins[20];
        pc_dst = (ins[15:12] == 4'd15);
        pass   = cond_pass(ins[31:28], mflags);
        rg     = {op == 2'b01 && !sb, op == 2'b10};
        im     = op;
        case (cmd)
            4'b0010, 4'b1010: ac = 2'b01;
            4'b0000:          ac = 2'b10;
            4'b1100:          ac = 2'b11;
            default:          ac = 2'b00;
        endcase
        exp_q.delete();
        exp_q.push_back(fetch_vec());
        exp_q.push_back(vec(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, rg, im, 2'b00));
        if (op == 2'b01) begin
            exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, rg, im, 2'b00));
            if (sb) begin
                exp_q.push_back(vec(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, rg, im, 2'b00));
                exp_q.push_back(vec(pass && pc_dst, 0, pass, 0, 0, 0, 2'b00, 2'b01,
                                    rg, im, 2'b00));
            end else begin
                exp_q.push_back(vec(0, pass, 0, 0, 1, 0, 2'b00, 2'b00, rg, im, 2'b00));
            end
        end else if (op == 2'b00) begin
            wr = pass && (cmd != 4'b1010);
            exp_q.push_back(vec(0, 0, 0, 0, 0, 0, ib ? 2'b01 : 2'b00, 2'b00, rg, im, ac));
            exp_q.push_back(vec(wr && pc_dst, 0, wr, 0, 0, 0, 2'b00, 2'b00, rg, im, 2'b00));
            if (sb && pass) mflags = af;
        end else if (op == 2'b10) begin
            exp_q.push_back(vec(pass, 0, 0, 0, 0, 0, 2'b01, 2'b10, rg, im, 2'b00));
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Entered just after a rising edge with the DUT in FETCH
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] af);
        Instr    = ins[31:12];
        ALUFlags = af;
        build_expect(ins, af);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", tag, i), obs, exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        Reset    = 1'b0;
        Instr    = '0;
        ALUFlags = '0;
        mflags   = 4'b0000;
        #12;
        check("reset_outputs", obs, reset_vec());
        @(posedge clk);
        #1 Reset = 1'b1;

        run_instr("add_reg",   32'hE0821003, 4'b1111);
        run_instr("subs_imm",  32'hE2500001, 4'b0100);
        run_instr("addeq",     32'h02811001, 4'b0000);
        run_instr("addne",     32'h12811001, 4'b0000);
        run_instr("ldr",       32'hE5954008, 4'b0000);
        run_instr("str",       32'hE5854008, 4'b0000);
        run_instr("b_al",      32'hEA000004, 4'b0000);
        run_instr("cmp",       32'hE1510002, 4'b1000);
        run_instr("addmi",     32'h42811001, 4'b0000);
        run_instr("addpl",     32'h52811001, 4'b0000);
        run_instr("add_pc",    32'hE082F003, 4'b0000);
        run_instr("ldr_pc",    32'hE595F008, 4'b0000);
        run_instr("never",     32'hF0821003, 4'b0000);
        run_instr("op11",      32'hEC000000, 4'b0000);
        run_instr("orr_s",     32'hE1910002, 4'b0001);
        run_instr("bvs",       32'h6A000001, 4'b0000);

        for (int n = 0; n < 80; n++) begin
            run_instr($sformatf("rand%0d", n), $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset mid-STR while in MEMWR
        Instr    = 32'hE5854008 >> 12;
        ALUFlags = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        compared++;
        assert (MemWrite === 1'b1) else begin
            mismatched++;
            $error("FAIL memwr_before_reset: observed %b expected 1", MemWrite);
        end
        #1 Reset = 1'b0;
        #1;
        compared++;
        assert (MemWrite === 1'b0) else begin
            mismatched++;
            $error("FAIL memwr_async_drop: observed %b expected 0", MemWrite);
        end
        check("reset_mid_instr", obs, reset_vec());
        @(posedge clk);
        #1 Reset = 1'b1;
        mflags = 4'b0000;
        run_instr("after_reset_eq", 32'h02811001, 4'b0000);
        run_instr("after_reset_add", 32'hE0821003, 4'b0000);
        @(negedge clk);
        check("final_fetch", obs, fetch_vec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
